// File: rtl/fir_feeder_if.sv
// FIR-side bus of the feeder: coefficient load and sample request handshakes.
// The feeder is the master; the FIR answers on modwait.
interface fir_feeder_if;
  logic [15:0] fir_coefficient;
  logic        load_coeff;
  logic [15:0] sample_data;
  logic        data_ready;
  logic        modwait;

  modport master (
    output fir_coefficient,
    output load_coeff,
    output sample_data,
    output data_ready,
    input  modwait
  );

  modport slave (
    input  fir_coefficient,
    input  load_coeff,
    input  sample_data,
    input  data_ready,
    output modwait
  );
endinterface

// File: rtl/fir_feeder.sv
// Feeds a FIR core: transfers 4 host-written coefficients on request and streams
// samples from a 4-deep FIFO, each through a modwait handshake with timeouts.
module fir_feeder (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] coeff_in,
  input  logic        coeff_wr,
  input  logic        load_start,
  input  logic [15:0] sample_in,
  input  logic        sample_wr,
  fir_feeder_if.master fir,
  output logic        fifo_full,
  output logic        fifo_empty,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE, LC_ASSERT, LC_WAIT_HI, LC_WAIT_LO, DR_ASSERT, DR_WAIT_LO
  } state_t;

  // Timer holds the index of the current cycle within a state; give up on the last one.
  localparam logic [4:0] LC_LAST = 5'd9;
  localparam logic [4:0] DR_LAST = 5'd24;

  state_t            state_reg, state_next;
  logic [4:0]        timer_reg, timer_next;
  logic [1:0]        ci_reg, ci_next;
  logic [1:0]        wr_idx_reg;
  logic [3:0][15:0]  coeff_bus;
  logic [15:0]       fifo_mem [4];
  logic [1:0]        rd_ptr_reg, rd_ptr_next, wr_ptr_reg, wr_ptr_next;
  logic [2:0]        count_reg, count_next;
  logic              pending_reg, pending_next;
  logic              err_reg;
  logic              pop, timeout, pop_en, push_en, overflow;
  logic [15:0]       head_next;
  logic              load_coeff_reg, data_ready_reg, busy_reg;
  logic              fifo_full_reg, fifo_empty_reg;
  logic [15:0]       fir_coefficient_reg, sample_data_reg;

  // Coefficient slots stay writable while a transfer is running.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slot
      logic [15:0] slot_reg;
      always_ff @(posedge clk) begin
        if (reset)
          slot_reg <= '0;
        else if (coeff_wr && wr_idx_reg == 2'(gi))
          slot_reg <= coeff_in;
      end
      assign coeff_bus[gi] = slot_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset)
      wr_idx_reg <= '0;
    else if (coeff_wr)
      wr_idx_reg <= wr_idx_reg + 2'd1;
  end

  always_comb begin
    state_next = state_reg;
    ci_next    = ci_reg;
    pop        = 1'b0;
    timeout    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pending_reg) begin
          state_next = LC_ASSERT;
          ci_next    = 2'd0;
        end else if (count_reg != 3'd0) begin
          state_next = DR_ASSERT;
        end
      end
      LC_ASSERT: begin
        if (timer_reg == 5'd1)
          state_next = LC_WAIT_HI;
      end
      LC_WAIT_HI: begin
        if (fir.modwait) begin
          state_next = LC_WAIT_LO;
        end else if (timer_reg == LC_LAST) begin
          state_next = IDLE;
          timeout    = 1'b1;
        end
      end
      LC_WAIT_LO: begin
        if (!fir.modwait) begin
          if (ci_reg == 2'd3) begin
            state_next = IDLE;
          end else begin
            state_next = LC_ASSERT;
            ci_next    = ci_reg + 2'd1;
          end
        end else if (timer_reg == LC_LAST) begin
          state_next = IDLE;
          timeout    = 1'b1;
        end
      end
      DR_ASSERT: begin
        if (timer_reg != 5'd0 && fir.modwait) begin
          state_next = DR_WAIT_LO;
        end else if (timer_reg == DR_LAST) begin
          state_next = IDLE;
          timeout    = 1'b1;
          pop        = 1'b1;
        end
      end
      DR_WAIT_LO: begin
        if (!fir.modwait) begin
          state_next = IDLE;
          pop        = 1'b1;
        end else if (timer_reg == DR_LAST) begin
          state_next = IDLE;
          timeout    = 1'b1;
          pop        = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    timer_next = timer_reg;
    if (state_next != state_reg)
      timer_next = 5'd0;
    else if (state_reg != IDLE)
      timer_next = timer_reg + 5'd1;
  end

  // A new strobe in the same cycle the transfer starts is kept as the next request.
  assign pending_next = load_start |
                        (pending_reg & ~(state_reg == IDLE && state_next == LC_ASSERT));

  assign pop_en      = pop && (count_reg != 3'd0);
  assign push_en     = sample_wr && ((count_reg != 3'd4) || pop_en);
  assign overflow    = sample_wr && !push_en;
  assign count_next  = count_reg + {2'b00, push_en} - {2'b00, pop_en};
  assign rd_ptr_next = rd_ptr_reg + {1'b0, pop_en};
  assign wr_ptr_next = wr_ptr_reg + {1'b0, push_en};

  // Next head: the incoming word is forwarded when it lands in the head slot.
  always_comb begin
    head_next = '0;
    if (count_next != 3'd0) begin
      if (push_en && wr_ptr_reg == rd_ptr_next)
        head_next = sample_in;
      else
        head_next = fifo_mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk) begin
    if (push_en)
      fifo_mem[wr_ptr_reg] <= sample_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg           <= IDLE;
      timer_reg           <= '0;
      ci_reg              <= '0;
      rd_ptr_reg          <= '0;
      wr_ptr_reg          <= '0;
      count_reg           <= '0;
      pending_reg         <= 1'b0;
      err_reg             <= 1'b0;
      load_coeff_reg      <= 1'b0;
      data_ready_reg      <= 1'b0;
      busy_reg            <= 1'b0;
      fifo_full_reg       <= 1'b0;
      fifo_empty_reg      <= 1'b1;
      fir_coefficient_reg <= '0;
      sample_data_reg     <= '0;
    end else begin
      state_reg           <= state_next;
      timer_reg           <= timer_next;
      ci_reg              <= ci_next;
      rd_ptr_reg          <= rd_ptr_next;
      wr_ptr_reg          <= wr_ptr_next;
      count_reg           <= count_next;
      pending_reg         <= pending_next;
      err_reg             <= err_reg | timeout | overflow;
      load_coeff_reg      <= (state_next == LC_ASSERT);
      data_ready_reg      <= (state_next == DR_ASSERT);
      busy_reg            <= (state_next != IDLE);
      fifo_full_reg       <= (count_next == 3'd4);
      fifo_empty_reg      <= (count_next == 3'd0);
      sample_data_reg     <= head_next;
      fir_coefficient_reg <= (state_next == LC_ASSERT || state_next == LC_WAIT_HI ||
                              state_next == LC_WAIT_LO) ? coeff_bus[ci_next] : 16'd0;
    end
  end

  assign fir.fir_coefficient = fir_coefficient_reg;
  assign fir.load_coeff      = load_coeff_reg;
  assign fir.sample_data     = sample_data_reg;
  assign fir.data_ready      = data_ready_reg;
  assign fifo_full           = fifo_full_reg;
  assign fifo_empty          = fifo_empty_reg;
  assign busy                = busy_reg;
  assign err                 = err_reg;

endmodule

// File: tb/tb_fir_feeder.sv
// Directed bench for fir_feeder: a scoreboard queue holds the expected FIR-side
// transactions, a monitor pops and compares them, a small FIR model drives modwait.
module tb_fir_feeder;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] coeff_in;
  logic        coeff_wr;
  logic        load_start;
  logic [15:0] sample_in;
  logic        sample_wr;
  logic        fifo_full, fifo_empty, busy, err;

  fir_feeder_if fir_bus ();

  fir_feeder dut (
    .clk        (clk),
    .reset      (reset),
    .coeff_in   (coeff_in),
    .coeff_wr   (coeff_wr),
    .load_start (load_start),
    .sample_in  (sample_in),
    .sample_wr  (sample_wr),
    .fir        (fir_bus),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_load;
    logic [15:0] val;
  } txn_t;

  txn_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          lc_count = 0;
  int          dr_count = 0;
  int          mw_falls = 0;
  int          dr_fall_cyc = 0;
  int          fir_mode = 0;   // 0 responsive FIR, 1 modwait stuck high, 2 modwait stuck low
  logic [15:0] coeff_model [4];
  logic [1:0]  widx_model = 2'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_txn(input logic is_load, input logic [15:0] val);
    txn_t e;
    $display("txn %s value=%h t=%0d", is_load ? "load_coeff" : "data_ready", val, cyc);
    checks++;
    assert (sb.size() != 0)
    else begin
      failures++;
      $error("FAIL sb_unexpected observed=%0h expected=none", val);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check("txn_kind", 32'(is_load), 32'(e.is_load));
      check("txn_value", 32'(val), 32'(e.val));
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // modwait fall counter, sampled on the edge the DUT sees
  initial begin
    logic mw_q;
    mw_q = 1'b0;
    forever begin
      @(posedge clk);
      if (mw_q && !fir_bus.modwait) mw_falls++;
      mw_q = fir_bus.modwait;
    end
  end

  // FIR model: modwait rises 2 cycles after a request rises, falls 1 cycle later
  initial begin
    int   cnt;
    logic prev_req, req;
    cnt = 0;
    prev_req = 1'b0;
    fir_bus.modwait = 1'b0;
    forever begin
      @(negedge clk);
      req = fir_bus.load_coeff | fir_bus.data_ready;
      if (fir_mode == 1) begin
        fir_bus.modwait = 1'b1;
        cnt = 0;
      end else if (fir_mode == 2) begin
        fir_bus.modwait = 1'b0;
        cnt = 0;
      end else begin
        if (req && !prev_req) cnt = 1;
        else if (cnt != 0) cnt++;
        fir_bus.modwait = (cnt == 3);
        if (cnt >= 4) cnt = 0;
      end
      prev_req = req;
    end
  end

  // Monitor: one scoreboard transaction per rising request, width checked on the fall
  initial begin
    logic lc_prev, dr_prev;
    int   lc_width, dr_width;
    lc_prev = 1'b0; dr_prev = 1'b0; lc_width = 0; dr_width = 0;
    forever begin
      @(negedge clk);
      if (fir_bus.load_coeff && !lc_prev) begin
        lc_count++;
        lc_width = 1;
        compare_txn(1'b1, fir_bus.fir_coefficient);
      end else if (fir_bus.load_coeff) begin
        lc_width++;
      end
      if (!fir_bus.load_coeff && lc_prev) check("lc_width", 32'(lc_width), 32'd2);
      if (fir_bus.data_ready && !dr_prev) begin
        dr_count++;
        dr_width = 1;
        compare_txn(1'b0, fir_bus.sample_data);
      end else if (fir_bus.data_ready) begin
        dr_width++;
      end
      if (!fir_bus.data_ready && dr_prev) begin
        check("dr_width_ge2", 32'(dr_width >= 2), 32'd1);
        dr_fall_cyc = cyc;
      end
      lc_prev = fir_bus.load_coeff;
      dr_prev = fir_bus.data_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) coeff_model[i] = 16'd0;
    widx_model = 2'd0;
  endtask

  task automatic check_reset_state();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_load_coeff", 32'(fir_bus.load_coeff), 32'd0);
    check("rst_data_ready", 32'(fir_bus.data_ready), 32'd0);
    check("rst_fir_coefficient", 32'(fir_bus.fir_coefficient), 32'd0);
    check("rst_sample_data", 32'(fir_bus.sample_data), 32'd0);
    check("rst_fifo_empty", 32'(fifo_empty), 32'd1);
    check("rst_fifo_full", 32'(fifo_full), 32'd0);
  endtask

  task automatic write_coeff(input logic [15:0] v);
    coeff_in = v;
    coeff_wr = 1'b1;
    coeff_model[widx_model] = v;
    widx_model = widx_model + 2'd1;
    @(negedge clk);
    coeff_wr = 1'b0;
  endtask

  task automatic expect_loads(input int n);
    txn_t t;
    for (int i = 0; i < n; i++) begin
      t.is_load = 1'b1;
      t.val = coeff_model[i];
      sb.push_back(t);
    end
  endtask

  task automatic push_sample(input logic [15:0] v, input logic accepted);
    txn_t t;
    sample_in = v;
    sample_wr = 1'b1;
    if (accepted) begin
      t.is_load = 1'b0;
      t.val = v;
      sb.push_back(t);
    end
    @(negedge clk);
    sample_wr = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    repeat (3) @(negedge clk);
    for (int n = 0; n < bound; n++) begin
      if (!busy && fifo_empty) break;
      @(negedge clk);
    end
    check("idle_reached", {30'd0, busy, fifo_empty}, 32'd1);
  endtask

  initial begin
    int lc0, dr0, mw0, busy_cycles;
    logic seen;
    reset = 1'b1; coeff_in = '0; coeff_wr = 1'b0; load_start = 1'b0;
    sample_in = '0; sample_wr = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();
    check_reset_state();

    // Coefficient transfer with a responsive FIR
    write_coeff(16'h4000); write_coeff(16'h8000);
    write_coeff(16'h8000); write_coeff(16'h4000);
    lc0 = lc_count; mw0 = mw_falls;
    expect_loads(4);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
      else if (seen) break;
    end
    check("busy_fall_after_modwait_falls", 32'(mw_falls - mw0), 32'd4);
    check("lc_pulses", 32'(lc_count - lc0), 32'd4);
    check("busy_after_load", 32'(busy), 32'd0);
    check("err_after_load", 32'(err), 32'd0);

    // Sample stream with a responsive FIR
    dr0 = dr_count;
    push_sample(16'h0100, 1'b1);
    check("head_after_push", 32'(fir_bus.sample_data), 32'h0100);
    check("not_empty_after_push", 32'(fifo_empty), 32'd0);
    push_sample(16'h1000, 1'b1);
    push_sample(16'h0100, 1'b1);
    push_sample(16'h0100, 1'b1);
    wait_idle(300);
    check("dr_pulses", 32'(dr_count - dr0), 32'd4);
    check("empty_after_stream", 32'(fifo_empty), 32'd1);
    check("err_after_stream", 32'(err), 32'd0);
    check("sb_drained_stream", 32'(sb.size()), 32'd0);

    // Fifth write wraps to slot 0; load and sample strobed together, load first
    write_coeff(16'hABCD);
    lc0 = lc_count; dr0 = dr_count;
    expect_loads(4);
    load_start = 1'b1;
    push_sample(16'h1234, 1'b1);
    load_start = 1'b0;
    wait_idle(300);
    check("prio_lc_pulses", 32'(lc_count - lc0), 32'd4);
    check("prio_dr_pulses", 32'(dr_count - dr0), 32'd1);
    check("sb_drained_prio", 32'(sb.size()), 32'd0);

    // modwait never rises during a load: 2 assert cycles + 10 wait cycles, then give up
    fir_mode = 2;
    lc0 = lc_count;
    expect_loads(1);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    busy_cycles = 0; seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (busy) begin
        seen = 1'b1;
        busy_cycles++;
      end else if (seen) break;
    end
    check("lc_timeout_busy_cycles", 32'(busy_cycles), 32'd12);
    check("lc_timeout_err", 32'(err), 32'd1);
    check("lc_timeout_busy", 32'(busy), 32'd0);
    check("lc_timeout_pulses", 32'(lc_count - lc0), 32'd1);
    do_reset();
    check("err_cleared_by_reset", 32'(err), 32'd0);

    // modwait stuck high: overflow on the fifth push, DR timeout still pops
    fir_mode = 1;
    dr0 = dr_count;
    push_sample(16'hA001, 1'b1);
    push_sample(16'hA002, 1'b1);
    push_sample(16'hA003, 1'b1);
    push_sample(16'hA004, 1'b1);
    check("full_after_4", 32'(fifo_full), 32'd1);
    check("err_before_overflow", 32'(err), 32'd0);
    push_sample(16'hA005, 1'b0);
    check("err_after_overflow", 32'(err), 32'd1);
    check("full_after_overflow", 32'(fifo_full), 32'd1);
    for (int n = 0; n < 60; n++) begin
      if (!fifo_full) break;
      @(negedge clk);
    end
    check("full_cleared_by_timeout_pop", 32'(fifo_full), 32'd0);
    check("dr_wait_lo_timeout_cycles", 32'(cyc - dr_fall_cyc), 32'd25);
    check("head_after_timeout_pop", 32'(fir_bus.sample_data), 32'hA002);
    wait_idle(300);
    check("stuck_dr_pulses", 32'(dr_count - dr0), 32'd4);
    check("err_sticky", 32'(err), 32'd1);
    fir_mode = 0;
    do_reset();
    check_reset_state();

    // Reset during LC_WAIT_HI of coefficient 2 abandons everything
    write_coeff(16'h1111); write_coeff(16'h2222);
    write_coeff(16'h3333); write_coeff(16'h4444);
    lc0 = lc_count; dr0 = dr_count;
    expect_loads(3);
    load_start = 1'b1;
    push_sample(16'h5555, 1'b0);
    load_start = 1'b0;
    push_sample(16'h6666, 1'b0);
    for (int n = 0; n < 100; n++) begin
      if (lc_count - lc0 == 3 && !fir_bus.load_coeff) break;
      @(negedge clk);
    end
    check("reached_third_wait_hi", 32'(lc_count - lc0), 32'd3);
    check("busy_in_third_wait_hi", 32'(busy), 32'd1);
    do_reset();
    check_reset_state();
    repeat (40) @(negedge clk);
    check("no_lc_after_reset", 32'(lc_count - lc0), 32'd3);
    check("no_dr_after_reset", 32'(dr_count - dr0), 32'd0);
    check("empty_after_reset", 32'(fifo_empty), 32'd1);
    check("sb_drained_final", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
